// File: rtl/sccb_write_master.sv
// rtl/sccb_write_master.sv - SCCB 3-phase write master for OV7670 configuration
//
// Accepts one {dev_addr, reg_addr, reg_data} triple per start/ready handshake
// and serialises it as an SCCB 3-phase write on sioc/siod.
//
// Optional build macro: SCCB_ACK_CHECK_EN
//   Adds siod_in (sampled in the three released slots) and a sticky ack_err.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             write request, accepted when ready=1
//   dev_addr          SCCB device ID byte including the W bit
//   reg_addr          camera register address
//   reg_data          register value
//   ready             idle and able to accept start
//   done              one-cycle pulse when a write completes
//   sioc              SCCB clock
//   siod, siod_oe     SCCB data value and drive enable
//   siod_in, ack_err  (SCCB_ACK_CHECK_EN only) sampled bus data, sticky error
module sccb_write_master #(
    parameter int CLK_FREQ  = 25000000,
    parameter int SCCB_FREQ = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
`ifdef SCCB_ACK_CHECK_EN
    input  logic       siod_in,
    output logic       ack_err,
`endif
    output logic       ready,
    output logic       done,
    output logic       sioc,
    output logic       siod,
    output logic       siod_oe
);

    localparam int QRAW    = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int QUARTER = (QRAW < 1) ? 1 : QRAW;
    localparam int QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BITS  = 3'd2,
        STOP  = 3'd3,
        FREE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]  phase_q, phase_d;   // quarter index within the current state/bit
    logic [4:0]  bit_q, bit_d;       // bit slot 0..26
    logic [26:0] sr_q, sr_d;         // MSB is the bit currently on the bus
    logic        done_q, done_d;
    logic        ack_q, ack_d;
    logic        tick;
    logic        slot_rel;

    assign tick     = (state_q != IDLE) && (qcnt_q == QW'(QUARTER - 1));
    // Slots 8, 17 and 26 are the don't-care/ACK slots where the bus is released.
    assign slot_rel = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            phase_q <= 2'd0;
            bit_q   <= 5'd0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        ack_d   = ack_q;
        sioc    = 1'b1;
        siod    = 1'b1;
        siod_oe = 1'b1;

        if (state_q == IDLE) begin
            qcnt_d = '0;
        end else if (tick) begin
            qcnt_d = '0;
        end else begin
            qcnt_d = qcnt_q + QW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    phase_d = 2'd0;
                    bit_d   = 5'd0;
                    sr_d    = {dev_addr, 1'b1, reg_addr, 1'b1, reg_data, 1'b1};
                    ack_d   = 1'b0;
                end
            end
            START: begin
                // siod falls while sioc is still high, then sioc drops.
                sioc = (phase_q != 2'd2);
                siod = 1'b0;
                if (tick) begin
                    if (phase_q == 2'd2) begin
                        state_d = BITS;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            BITS: begin
                sioc    = (phase_q == 2'd1) || (phase_q == 2'd2);
                siod_oe = !slot_rel;
                siod    = slot_rel ? 1'b1 : sr_q[26];
`ifdef SCCB_ACK_CHECK_EN
                if (slot_rel && tick && (phase_q == 2'd1) && siod_in) begin
                    ack_d = 1'b1;
                end
`endif
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        sr_d = {sr_q[25:0], 1'b0};
                        if (bit_q == 5'd26) begin
                            state_d = STOP;
                            phase_d = 2'd0;
                            bit_d   = 5'd0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            STOP: begin
                // siod rises while sioc is high in the last quarter.
                sioc = (phase_q != 2'd0);
                siod = (phase_q == 2'd2);
                if (tick) begin
                    if (phase_q == 2'd2) begin
                        state_d = FREE;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            FREE: begin
                if (tick) begin
                    if (phase_q == 2'd3) begin
                        state_d = IDLE;
                        phase_d = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;

`ifdef SCCB_ACK_CHECK_EN
    assign ack_err = ack_q;
`endif

endmodule

// File: tb/tb_sccb_write_master.sv
// tb/tb_sccb_write_master.sv - scoreboard bench for sccb_write_master
module tb_sccb_write_master;

    localparam int     Q     = 62;
    localparam longint FRAME = 118 * Q;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dev_addr = 8'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] reg_data = 8'h00;
    logic       ready, done, sioc, siod, siod_oe;
`ifdef SCCB_ACK_CHECK_EN
    logic       siod_in = 1'b0;
    logic       ack_err;
`endif

    sccb_write_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
`ifdef SCCB_ACK_CHECK_EN
        .siod_in  (siod_in),
        .ack_err  (ack_err),
`endif
        .ready    (ready),
        .done     (done),
        .sioc     (sioc),
        .siod     (siod),
        .siod_oe  (siod_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic        aborted;
        logic        nack;
    } exp_t;

    typedef struct packed {
        longint t;
        logic   nack;
    } dexp_t;

    exp_t   eq[$];
    dexp_t  dq[$];
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- bus monitor: decodes frames from sioc/siod ----------------
    logic        psioc = 1'b1, psiod = 1'b1;
    logic        in_frame = 1'b0;
    int          nr = 0;
    logic [26:0] cap_d, cap_oe;

    task automatic close_frame(input logic by_reset);
        exp_t        e;
        logic [23:0] got;
        logic [26:0] oe_exp;
        in_frame = 1'b0;
        if (eq.size() == 0) begin
            chk("frame_unexpected", 1, 0);
            return;
        end
        e = eq.pop_front();
        chk("frame_aborted", longint'(by_reset), longint'(e.aborted));
        if (by_reset) return;
        got = '0;
        for (int i = 0; i < 27; i++) begin
            oe_exp[i] = (i % 9 != 8);
            if (i % 9 != 8) got = {got[22:0], cap_d[i]};
        end
        chk("sioc_rises", nr, 28);
        chk("frame_data", got, e.d);
        chk("frame_oe", cap_oe, oe_exp);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_frame) close_frame(1'b1);
            psioc = 1'b1;
            psiod = 1'b1;
`ifdef SCCB_ACK_CHECK_EN
            siod_in = 1'b0;
`endif
        end else begin
            if (psioc && sioc && psiod && !siod) begin
                if (in_frame) chk("nested_start", 1, 0);
                in_frame = 1'b1;
                nr = 0;
                cap_d = '1;
                cap_oe = '1;
            end else if (psioc && sioc && !psiod && siod) begin
                if (in_frame) close_frame(1'b0);
                else chk("stray_stop", 1, 0);
            end
            if (!psioc && sioc && in_frame) begin
                if (nr < 27) begin
                    cap_d[nr] = siod;
                    cap_oe[nr] = siod_oe;
                end
`ifdef SCCB_ACK_CHECK_EN
                siod_in = (nr == 17) && (eq.size() > 0) && eq[0].nack;
`endif
                nr++;
            end
`ifdef SCCB_ACK_CHECK_EN
            if (psioc && !sioc) siod_in = 1'b0;
`endif
            psioc = sioc;
            psiod = siod;
        end
    end

    // ---------------- done monitor ----------------
    always @(negedge clk) begin
        dexp_t e;
        if (rst_n && done) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = dq.pop_front();
                chk("done_cycle", cyc, e.t);
`ifdef SCCB_ACK_CHECK_EN
                chk("ack_err_at_done", longint'(ack_err), longint'(e.nack));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] d, input logic [7:0] r, input logic [7:0] v,
                         input logic nack, output longint a);
        dev_addr = d;
        reg_addr = r;
        reg_data = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = cyc;
        eq.push_back('{d: {d, r, v}, aborted: 1'b0, nack: nack});
        dq.push_back('{t: a + FRAME, nack: nack});
    endtask

    initial begin
        longint a, a1;
        exp_t   ex;
        dexp_t  dx;

        repeat (5) @(negedge clk);
        chk("rst_sioc", sioc, 1);
        chk("rst_siod", siod, 1);
        chk("rst_oe", siod_oe, 1);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write plus a start pulse while busy
        issue(8'h42, 8'h12, 8'h80, 1'b0, a);
        wait_until(a + 100);
        dev_addr = 8'h42; reg_addr = 8'h55; reg_data = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(a + FRAME + 1);

        // back-to-back with start held high
        dev_addr = 8'h42; reg_addr = 8'h11; reg_data = 8'h01; start = 1'b1;
        @(negedge clk);
        a1 = cyc;
        eq.push_back('{d: 24'h421101, aborted: 1'b0, nack: 1'b0});
        dq.push_back('{t: a1 + FRAME, nack: 1'b0});
        wait_until(a1 + FRAME);
        reg_addr = 8'h0C; reg_data = 8'h04;
        eq.push_back('{d: 24'h420C04, aborted: 1'b0, nack: 1'b0});
        dq.push_back('{t: a1 + 2 * FRAME + 1, nack: 1'b0});
        @(negedge clk);
        start = 1'b0;
        wait_until(a1 + 2 * FRAME + 2);

        // randomized writes with random idle gaps
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            issue(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, a);
            wait_until(a + FRAME + 1);
        end

        // reset during bit 12, applied between clock edges
        issue(8'h42, 8'($urandom), 8'($urandom), 1'b0, a);
        wait_until(a + 53 * Q + 10);
        #2;
        ex = eq.pop_back();
        ex.aborted = 1'b1;
        eq.push_back(ex);
        dx = dq.pop_back();
        rst_n = 1'b0;
        #1;
        chk("midrst_sioc", sioc, 1);
        chk("midrst_siod", siod, 1);
        chk("midrst_oe", siod_oe, 1);
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h42, 8'h3A, 8'h5C, 1'b0, a);
        wait_until(a + FRAME + 1);

`ifdef SCCB_ACK_CHECK_EN
        issue(8'h42, 8'h12, 8'h80, 1'b1, a);
        wait_until(a + FRAME + 1);
        issue(8'h42, 8'h13, 8'hE7, 1'b0, a);
        chk("ack_err_cleared", ack_err, 0);
        wait_until(a + FRAME + 1);
`endif

        repeat (4) @(negedge clk);
        chk("frames_pending", eq.size(), 0);
        chk("dones_pending", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(990000);
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
- Downstream stage of the camera configuration sequencer.
- Accepts one {device ID, register address, register data} triple per handshake.
- Serialises the triple as an SCCB 3-phase write on sioc/siod to the OV7670.
- Write-only; the sequencer waits on ready/done before issuing the next ROM entry.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
SCCB_FREQ, 100000, SCCB bit rate in Hz
QUARTER (localparam), CLK_FREQ/(4*SCCB_FREQ), clamped to a minimum of 1; clocks per quarter bit period (62 at defaults)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active low
start  input  1  request a write; accepted only when ready=1
dev_addr  input  8  SCCB device ID byte including the W bit (0x42 for OV7670 write)
reg_addr  input  8  camera register address
reg_data  input  8  value to write
ready  output  1  high when idle and able to accept start
done  output  1  one-cycle pulse when a write fully completes
sioc  output  1  SCCB clock
siod  output  1  SCCB data (value driven when siod_oe=1)
siod_oe  output  1  1 = master drives siod; 0 = released (don't-care bit slots)

Behaviour:
- Reset (async assert, sync-style release): sioc=1, siod=1, siod_oe=1, ready=1, done=0, state=IDLE, quarter counter=0, bit counter=0.
- Accept: rising clk with start=1 and ready=1.
  - dev_addr/reg_addr/reg_data latched into a 27-bit shift register: {dev_addr,X,reg_addr,X,reg_data,X}.
  - ready=0 from the next cycle.
  - start while ready=0 is ignored. No queueing.
- Quarter tick: counter counts 0..QUARTER-1 and ticks on wrap. The counter is held at 0 in IDLE.
- FSM states: IDLE -> START -> BITS -> STOP -> FREE -> IDLE.
- START, 3 quarters:
  - q0, q1: sioc=1, siod=0 (start condition: siod falls while sioc is high).
  - q2: sioc=0.
- BITS, 27 bits of 4 quarters each, MSB first:
  - q0: siod updated to the current bit; sioc=0.
  - q1, q2: sioc=1.
  - q3: sioc=0.
  - siod changes only while sioc=0.
  - Bit slots 8, 17, 26 (the don't-care/ACK slots) use siod_oe=0 and siod=1.
- STOP, 3 quarters:
  - q0: sioc=0, siod=0.
  - q1: sioc=1, siod=0.
  - q2: sioc=1, siod=1 (stop condition: siod rises while sioc is high).
- FREE: 4 quarters with sioc=1, siod=1 (bus free time).
  - On the final tick: done=1 for one cycle, ready=1 in the same cycle, then return to IDLE.
- Latency:
  - done asserts exactly 118*QUARTER clk cycles after the accepting edge (7316 at defaults).
  - start may be reasserted in the done cycle and is accepted then. Back-to-back writes have no extra gap beyond FREE.
- start held continuously high: one write per 118*QUARTER+1 cycles, each latching the inputs present at its accept edge.
- Inputs changing mid-transfer have no effect.
- Reset mid-transfer: outputs go immediately to their reset values. The partial frame is abandoned; the sensor resynchronises on the next start condition. No done pulse is issued.

Optional Feature:
SCCB_ACK_CHECK_EN
- Defined:
  - Adds input siod_in (1) and output ack_err (1).
  - siod_in is sampled at the last clk of q1 in each released slot (8, 17, 26).
  - siod_in=1 sets a sticky error flag.
  - ack_err mirrors that flag; it is valid in the done cycle and held until the next accept, which clears it.
  - Reset value 0.
  - The transfer always completes regardless of ack_err.
- Undefined: no siod_in or ack_err ports; released slots are not sampled.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles -> sioc=1, siod=1, siod_oe=1, ready=1, done=0. Assert rst_n=0 mid-cycle -> outputs change without waiting for a clk edge.
- Single write, dev=0x42, reg=0x12, data=0x80, QUARTER=62:
  - start condition seen; siod sampled on sioc rises decodes 42,X,12,X,80,X; stop condition seen.
  - siod_oe=0 only in slots 8/17/26; siod never changes while sioc=1 except at start/stop.
  - done pulses once, 7316 cycles after accept.
- Busy ignore: pulse start again 100 cycles after accept with different data -> no second frame; exactly one done.
- Back-to-back: hold start=1 with (0x42,0x11,0x01) then (0x42,0x0C,0x04) -> two frames, second accepted in the first done cycle; done pulses 7317 cycles apart.
- Reset mid-transfer: assert rst_n=0 during bit 12 -> sioc=siod=1, ready=1, no done. After release, a new write completes normally.
- With SCCB_ACK_CHECK_EN:
  - siod_in=1 during slot 17 only -> ack_err=1 at done.
  - Next write with siod_in=0 -> ack_err=0 after that accept and 0 at its done.
